// File: rtl/mips_mem_responder.sv
// mips_mem_responder: memory-side responder for the 64-bit multicycle MIPS core.
// It serves combinational reads and clocked byte/word/doubleword stores from an
// internal array. It also decodes an MMIO window holding a cycle counter, a
// store counter and an LED register. A boot loader fills the array from a
// stream while it holds the core in reset.
//
// Ports:
//   clk, reset         system clock; asynchronous active-high reset
//   dataadr            byte address from the core
//   writedata          lane-aligned store data
//   memwrite           00 none, 01 byte, 10 word, 11 doubleword
//   dtype              1 = instruction fetch (counted in fetch_count)
//   readdata           combinational read data (array or MMIO)
//   load_valid/data    loader stream word
//   load_last          marks the final word
//   load_ready         loader can accept a word (BOOT only)
//   cpu_reset          core reset, high while booting
//   led                LED register
//   fetch_count        RUN cycles with dtype=1
module mips_mem_responder #(
    parameter int N     = 64,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] dataadr,
    input  logic [N-1:0] writedata,
    input  logic [1:0]   memwrite,
    input  logic         dtype,
    output logic [N-1:0] readdata,
    input  logic         load_valid,
    input  logic [N-1:0] load_data,
    input  logic         load_last,
    output logic         load_ready,
    output logic         cpu_reset,
    output logic [7:0]   led,
    output logic [31:0]  fetch_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = N / 8;

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   load_ptr_q;
    logic [N-1:0]    mem [DEPTH];
    logic [N-1:0]    cyc_q;
    logic [N-1:0]    stc_q;
    logic [7:0]      led_q;
    logic [31:0]     fetch_q;

    logic [AW-1:0]   idx;
    logic            mmio;
    logic [2:0]      moff;
    logic            run;
    logic            accept;
    logic            store;
    logic            arr_we;
    logic            led_we;
    logic [NB-1:0]   be;

    // Upper address bits only matter for the MMIO decode; the rest alias.
    logic            unused_adr;
    assign unused_adr = ^dataadr;

    assign idx    = dataadr[AW+2:3];
    assign mmio   = (dataadr[15:12] == 4'hF);
    assign moff   = dataadr[5:3];
    assign run    = (state_q == RUN);
    assign store  = run && (memwrite != 2'b00);
    assign arr_we = store && !mmio;
    assign led_we = store && mmio && (moff == 3'd2);

    assign led         = led_q;
    assign fetch_count = fetch_q;

    // Boot FSM: next state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        load_ready = 1'b0;
        cpu_reset  = 1'b0;
        unique case (state_q)
            BOOT: begin
                load_ready = 1'b1;
                cpu_reset  = 1'b1;
                accept     = load_valid;
                if (load_valid &&
                    (load_last || load_ptr_q == AW'(DEPTH - 1)))
                    state_d = RUN;
            end
            RUN: begin
                state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // Little-endian byte-lane enables for the store type.
    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++) begin
            unique case (memwrite)
                2'b01:   be[b] = (b == int'(dataadr[2:0]));
                2'b10:   be[b] = ((b / 4) == int'(dataadr[2]));
                2'b11:   be[b] = 1'b1;
                default: be[b] = 1'b0;
            endcase
        end
    end

    always_comb begin
        readdata = mem[idx];
        if (mmio) begin
            unique case (moff)
                3'd0:    readdata = cyc_q;
                3'd1:    readdata = stc_q;
                3'd2:    readdata = {{(N-8){1'b0}}, led_q};
                default: readdata = '0;
            endcase
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[load_ptr_q] <= load_data;
        end else if (arr_we) begin
            for (int b = 0; b < NB; b++)
                if (be[b])
                    mem[idx][8*b +: 8] <= writedata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            load_ptr_q <= '0;
            cyc_q      <= '0;
            stc_q      <= '0;
            led_q      <= '0;
            fetch_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                load_ptr_q <= load_ptr_q + AW'(1);
            if (run) begin
                cyc_q <= cyc_q + N'(1);
                if (store)
                    stc_q <= stc_q + N'(1);
                if (dtype)
                    fetch_q <= fetch_q + 32'd1;
                if (led_we)
                    led_q <= writedata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: directed checks of boot loading, stores, MMIO,
// counters and reset behaviour of mips_mem_responder.
module tb_mips_mem_responder;

    localparam int N     = 64;
    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;
    logic [1:0]   memwrite;
    logic         dtype;
    logic [N-1:0] readdata;
    logic         load_valid;
    logic [N-1:0] load_data;
    logic         load_last;
    logic         load_ready;
    logic         cpu_reset;
    logic [7:0]   led;
    logic [31:0]  fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    mips_mem_responder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .memwrite    (memwrite),
        .dtype       (dtype),
        .readdata    (readdata),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_reset   (cpu_reset),
        .led         (led),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [63:0] adr,
                      input logic [63:0] exp);
        dataadr = adr;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic ld(input logic [63:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic st(input logic [63:0] adr, input logic [1:0] mw,
                      input logic [63:0] wd);
        dataadr   = adr;
        memwrite  = mw;
        writedata = wd;
        tick();
        memwrite  = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        chk("rst_led", {56'd0, led}, 64'd0);
        tick();
        reset = 1'b0;
    endtask

    logic [9:0] pat;

    initial begin
        reset      = 1'b1;
        dataadr    = '0;
        writedata  = '0;
        memwrite   = 2'b00;
        dtype      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        pat        = 10'b0101101011;
        tick();
        tick();
        chk("reset_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        chk("reset_load_ready", {63'd0, load_ready}, 64'd1);
        chk("reset_led", {56'd0, led}, 64'd0);
        chk("reset_fetch", {32'd0, fetch_count}, 64'd0);
        reset = 1'b0;
        tick();

        // Boot 4 words; last word ends BOOT.
        ld(64'h11, 1'b0);
        ld(64'h22, 1'b0);
        ld(64'h33, 1'b0);
        chk("boot_still", {63'd0, cpu_reset}, 64'd1);
        ld(64'h44, 1'b1);

        // RUN cycles 1..10 with 6 fetches.
        for (int c = 0; c < 10; c++) begin
            dtype = pat[c];
            if (c == 0) begin
                chk("run_cpu_reset", {63'd0, cpu_reset}, 64'd0);
                chk("run_load_ready", {63'd0, load_ready}, 64'd0);
                rd("cyc_first", 64'hF000, 64'd0);
                rd("boot_w0", 64'h0, 64'h11);
                rd("boot_w1", 64'h8, 64'h22);
                rd("boot_w2", 64'h10, 64'h33);
                rd("boot_w3", 64'h18, 64'h44);
            end
            if (c == 9) begin
                rd("cyc_c10", 64'hF000, 64'd9);
                chk("fetch_c10", {32'd0, fetch_count}, 64'd6);
            end
            tick();
        end
        dtype = 1'b0;
        chk("fetch_after", {32'd0, fetch_count}, 64'd6);
        rd("stc_zero", 64'hF008, 64'd0);

        // Lane stores.
        st(64'h20, 2'b11, 64'h0);
        st(64'h21, 2'b01, 64'hAB00);
        rd("byte_st", 64'h20, 64'h0000_0000_0000_AB00);
        dataadr   = 64'h24;
        memwrite  = 2'b10;
        writedata = 64'hDEADBEEF_00000000;
        #1;
        chk("same_cyc_old", readdata, 64'h0000_0000_0000_AB00);
        tick();
        memwrite = 2'b00;
        rd("word_st", 64'h20, 64'hDEADBEEF_0000AB00);
        rd("alias", 64'h820, 64'hDEADBEEF_0000AB00);

        // MMIO.
        st(64'hF010, 2'b11, 64'h5A);
        chk("led_set", {56'd0, led}, 64'h5A);
        rd("led_rd", 64'hF010, 64'h5A);
        rd("mmio_no_arr", 64'h10, 64'h33);
        rd("stc_4", 64'hF008, 64'd4);
        st(64'hF018, 2'b11, 64'hFF);
        chk("led_keep", {56'd0, led}, 64'h5A);
        rd("mmio_other", 64'hF018, 64'd0);
        rd("mmio_other_arr", 64'h18, 64'h44);
        rd("stc_5", 64'hF008, 64'd5);

        // Loader ignored in RUN.
        ld(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        rd("run_ld_ign0", 64'h20, 64'hDEADBEEF_0000AB00);
        rd("run_ld_ign1", 64'h0, 64'h11);
        chk("run_ld_cpu", {63'd0, cpu_reset}, 64'd0);

        // Reset mid-load.
        do_reset();
        chk("mid_fetch", {32'd0, fetch_count}, 64'd0);
        ld(64'hA1, 1'b0);
        ld(64'hA2, 1'b0);
        do_reset();
        chk("mid_ready", {63'd0, load_ready}, 64'd1);
        ld(64'hB0, 1'b1);
        chk("mid_run", {63'd0, cpu_reset}, 64'd0);
        rd("mid_idx0", 64'h0, 64'hB0);
        rd("mid_idx1", 64'h8, 64'hA2);

        // Full-depth boot, with stores attempted during BOOT.
        do_reset();
        st(64'hF010, 2'b11, 64'h77);
        chk("boot_led_ign", {56'd0, led}, 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1)
                chk("full_pre", {63'd0, cpu_reset}, 64'd1);
            ld(64'h1000 + 64'(i), 1'b0);
        end
        chk("full_run", {63'd0, cpu_reset}, 64'd0);
        rd("full_cyc0", 64'hF000, 64'd0);
        rd("full_stc0", 64'hF008, 64'd0);
        rd("full_first", 64'h0, 64'h1000);
        rd("full_last", 64'h7F8, 64'h10FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the 64-bit multicycle MIPS core's data/instruction port. It serves the core's combinational-read, clocked-write memory interface from an internal doubleword array and decodes a small MMIO window (cycle counter, store counter, LED register). A boot loader FSM fills the array from an external stream while holding the core in reset, then releases it.

## Interface
Parameters:
- N, 64, data/address width of the core port
- DEPTH, 256, array size in N-bit doublewords (power of two)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- dataadr  input  N  byte address from core
- writedata  input  N  store data from core, lane-aligned as an N-bit doubleword
- memwrite  input  2  store type: 00 none, 01 byte, 10 word (32-bit), 11 doubleword
- dtype  input  1  1 = instruction fetch, 0 = data access (reads only; ignored for stores)
- readdata  output  N  aligned doubleword at dataadr, or MMIO register
- load_valid  input  1  loader stream word valid
- load_data  input  N  loader stream word
- load_last  input  1  qualifies final loader word
- load_ready  output  1  loader can accept a word
- cpu_reset  output  1  reset to the core; high while booting
- led  output  8  LED register
- fetch_count  output  32  number of cycles with dtype=1 in RUN

## Operation
- FSM states: BOOT, RUN. Reset enters BOOT with load_ptr=0.
- BOOT: load_ready=1, cpu_reset=1. On load_valid, mem[load_ptr] <= load_data, load_ptr++. Go to RUN after an accepted word with load_last=1, or after an accepted word at load_ptr=DEPTH-1.
- RUN: load_ready=0, cpu_reset=0. load_valid is ignored. Only a reset returns the FSM to BOOT.
- Array index = dataadr[log2(DEPTH)+2:3]. Higher address bits are ignored, so addresses alias, except in the MMIO window.
- MMIO window is dataadr[15:12]==4'hF, decoded on dataadr[5:3]:
  - 0: cycle counter, read-only, N bits
  - 1: store counter, read-only, N bits
  - 2: LED register; a store writes led <= writedata[7:0] (any store type); a read returns led zero-extended
  - other offsets read 0 and ignore stores
- MMIO stores never modify the array.
- Stores (RUN only, memwrite≠00), little-endian lanes:
  - byte: lane dataadr[2:0], taking writedata[8*lane+7:8*lane]
  - word: half dataadr[2], taking the matching 32 bits of writedata
  - doubleword: all 64 bits
  - Unwritten lanes are preserved.
- Store counter increments on every RUN cycle with memwrite≠00, MMIO stores included.
- Cycle counter increments every RUN cycle.
- fetch_count increments every RUN cycle with dtype=1.
- All counters wrap at their width.
- Stores asserted during BOOT are ignored.

## Timing
- readdata is combinational from dataadr in the same cycle. No read latency.
- Array, LED and counter updates occur at the rising clk edge.
- A read in the cycle after a store returns the new data. A read in the same cycle as a store returns the old data.
- cpu_reset falls on the first RUN cycle, i.e. the cycle after the edge that accepted the last word. The cycle counter reads 0 in that cycle.
- Reset values: cpu_reset=1, load_ready=1, led=0, fetch_count=0, counters=0, state=BOOT. Array contents are not reset.
- Reset mid-load: returns to BOOT with load_ptr=0. Previously loaded words are retained but will be overwritten by the reload.
- A store and a counter read in the same cycle: the read returns the pre-increment value.

## Test plan
- Boot: stream 4 words 0x11..0x44, with load_last on the 4th -> cpu_reset falls the next cycle; readdata at dataadr 0x0, 0x8, 0x10, 0x18 = 0x11, 0x22, 0x33, 0x44; load_ready=0.
- Byte/word/dword stores: after a dword store of 0 to 0x20, a byte store of writedata=0xAB00 at 0x21 -> readdata 0x000000000000AB00. Then a word store of writedata=0xDEADBEEF_00000000 at 0x24 -> 0xDEADBEEF0000AB00.
- MMIO: store 0x5A to 0xF010 -> led=0x5A and array index 2 unchanged. Read 0xF008 after 3 stores in RUN -> 4 (includes the LED store).
- Counters: 10 RUN cycles with dtype=1 on 6 of them -> fetch_count=6; a read of 0xF000 in cycle 10 returns 9.
- Boundary: stream DEPTH words with no load_last -> RUN after word DEPTH-1. Assert reset mid-load after 2 words -> cpu_reset=1, led=0, next accepted word lands at index 0. A load_valid pulse during RUN -> no array change.
